// File: rtl/updown_ctrl_pkg.sv
// Shared types and default widths for the up/down sweep sequencer.
// The state enum is the single source of truth for FSM encoding.
package updown_ctrl_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int NSW_W_DEF = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_UP,
      S_DOWN,
      S_DONE
   } state_t;

endpackage

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer: drives an external up/down counter lo->hi->lo for a
// programmed number of sweeps, closing the loop on the counter value.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; rejects bad bounds with a one-cycle err
// LOAD   | counter loads latched lo
// UP     | stepping up; one dwell cycle once cnt_val reaches hi
// DOWN   | stepping down; dwell at lo ends a sweep
// DONE   | one-cycle done pulse, then back to IDLE
module updown_sweep_ctrl
   import updown_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int NSW_W = NSW_W_DEF
) (
   input  logic             Clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic [NSW_W-1:0] nsweeps,
   input  logic [WIDTH-1:0] cnt_val,
   output logic             cnt_load,
   output logic [WIDTH-1:0] cnt_load_val,
   output logic             cnt_en,
   output logic             cnt_up,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [NSW_W-1:0] sweep_idx
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lo_q, hi_q;
   logic [NSW_W-1:0] nsw_q;
   logic [NSW_W-1:0] idx_q, idx_d, idx_inc;
   logic             err_q, err_d;
   logic             latch_cfg;

   assign idx_inc = idx_q + NSW_W'(1);

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         lo_q    <= '0;
         hi_q    <= '0;
         nsw_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         if (latch_cfg) begin
            lo_q  <= lo;
            hi_q  <= hi;
            nsw_q <= nsweeps;
         end
      end
   end

   // Abort is folded into cnt_en here so the counter freezes in the abort cycle.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      err_d     = 1'b0;
      latch_cfg = 1'b0;
      cnt_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if ((lo < hi) && (nsweeps != '0)) begin
                  latch_cfg = 1'b1;
                  idx_d     = '0;
                  state_d   = S_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: state_d = abort ? S_IDLE : S_UP;
         S_UP: begin
            if (abort)                state_d = S_IDLE;
            else if (cnt_val >= hi_q) state_d = S_DOWN;
            else                      cnt_en  = 1'b1;
         end
         S_DOWN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (cnt_val <= lo_q) begin
               idx_d   = idx_inc;
               state_d = (idx_inc == nsw_q) ? S_DONE : S_UP;
            end else begin
               cnt_en = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign cnt_load     = (state_q == S_LOAD) && !abort;
   assign cnt_up       = (state_q == S_UP);
   assign busy         = (state_q == S_LOAD) || (state_q == S_UP) || (state_q == S_DOWN);
   assign done         = (state_q == S_DONE);
   assign err          = err_q;
   assign sweep_idx    = idx_q;
   assign cnt_load_val = lo_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl: behavioural counter, queue-based expected
// trace per accepted start, directed scenarios then randomized traffic.
module tb_updown_sweep_ctrl;

   logic       Clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] lo = 4'd0;
   logic [3:0] hi = 4'd0;
   logic [3:0] nsweeps = 4'd0;
   logic [3:0] cnt_val;
   logic       cnt_load;
   logic [3:0] cnt_load_val;
   logic       cnt_en;
   logic       cnt_up;
   logic       busy;
   logic       done;
   logic       err;
   logic [3:0] sweep_idx;

   logic [3:0] cnt_q = 4'd0;
   assign cnt_val = cnt_q;

   updown_sweep_ctrl #(.WIDTH(4), .NSW_W(4)) dut (
      .Clk(Clk), .reset_n(reset_n), .start(start), .abort(abort),
      .lo(lo), .hi(hi), .nsweeps(nsweeps), .cnt_val(cnt_val),
      .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .cnt_en(cnt_en),
      .cnt_up(cnt_up), .busy(busy), .done(done), .err(err), .sweep_idx(sweep_idx)
   );

   always #5 Clk = ~Clk;

   // Counter datapath: load beats enable, value visible after the edge.
   always @(posedge Clk) begin
      if (cnt_load)    cnt_q <= cnt_load_val;
      else if (cnt_en) cnt_q <= cnt_up ? cnt_q + 4'd1 : cnt_q - 4'd1;
   end

   typedef struct {
      bit load; bit en; bit up; bit busy; bit done;
      int idx; int val; bit vchk;
   } exp_t;

   exp_t exp_q[$];
   int   m_idx = 0;
   int   m_lo = 0;
   bit   err_pend = 0;

   int n_checks = 0;
   int n_errors = 0;

   int busy_run = 0, busy_total = 0, done_total = 0, err_total = 0;
   int cyc_since = 0, done_at = -1;
   int log_q[$];

   task automatic chk(input string nm, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   // Expected per-cycle trace of a whole run, straight from the sweep rules.
   task automatic build(input int l, input int h, input int ns);
      exp_q.push_back('{load:1, en:0, up:0, busy:1, done:0, idx:0, val:0, vchk:0});
      for (int k = 0; k < ns; k++) begin
         for (int v = l; v <= h; v++)
            exp_q.push_back('{load:0, en:(v != h), up:1, busy:1, done:0, idx:k, val:v, vchk:1});
         for (int v = h; v >= l; v--)
            exp_q.push_back('{load:0, en:(v != l), up:0, busy:1, done:0, idx:k, val:v, vchk:1});
      end
      exp_q.push_back('{load:0, en:0, up:0, busy:0, done:1, idx:ns, val:l, vchk:1});
   endtask

   // One cycle: compare at negedge, advance the model, return at posedge+1.
   task automatic tick();
      exp_t e;
      bit   idle;
      @(negedge Clk);
      if (!reset_n) begin
         exp_q.delete();
         m_idx = 0; m_lo = 0; err_pend = 0;
      end else begin
         idle = (exp_q.size() == 0);
         if (idle) e = '{load:0, en:0, up:0, busy:0, done:0, idx:m_idx, val:0, vchk:0};
         else      e = exp_q[0];
         if (!idle && abort && e.busy) begin
            e.en = 0; e.load = 0;
         end
         chk("cnt_load", int'(cnt_load), int'(e.load));
         chk("cnt_en", int'(cnt_en), int'(e.en));
         chk("cnt_up", int'(cnt_up), int'(e.up));
         chk("busy", int'(busy), int'(e.busy));
         chk("done", int'(done), int'(e.done));
         chk("err", int'(err), int'(err_pend));
         chk("sweep_idx", int'(sweep_idx), e.idx);
         chk("cnt_load_val", int'(cnt_load_val), m_lo);
         if (e.vchk) chk("cnt_val", int'(cnt_val), e.val);

         cyc_since++;
         if (busy) begin busy_run++; busy_total++; end
         if (done) begin done_total++; done_at = cyc_since; end
         if (err) err_total++;
         if ((busy && !cnt_load) || done) log_q.push_back(int'(cnt_val));

         err_pend = 0;
         if (!idle) begin
            if (abort && e.busy) begin
               exp_q.delete();
               m_idx = e.idx;
            end else begin
               void'(exp_q.pop_front());
               if (e.done) m_idx = e.idx;
            end
         end else if (start) begin
            if ((lo < hi) && (nsweeps != 0)) begin
               build(int'(lo), int'(hi), int'(nsweeps));
               m_lo = int'(lo); m_idx = 0;
               busy_run = 0; cyc_since = 0; done_at = -1;
               log_q.delete();
            end else begin
               err_pend = 1;
            end
         end
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic go(input int l, input int h, input int ns);
      lo = 4'(l); hi = 4'(h); nsweeps = 4'(ns); start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_err"}, int'(err), 0);
      chk({tag, "_load"}, int'(cnt_load), 0);
      chk({tag, "_en"}, int'(cnt_en), 0);
      chk({tag, "_up"}, int'(cnt_up), 0);
      chk({tag, "_idx"}, int'(sweep_idx), 0);
      chk({tag, "_lval"}, int'(cnt_load_val), 0);
   endtask

   initial begin
      int t1_exp[9] = '{2, 3, 4, 5, 5, 4, 3, 2, 2};
      int d0, b0, e0, v0, found;

      #2;
      chk_all_zero("reset");
      @(posedge Clk); #1;
      run(2);
      reset_n = 1'b1;
      run(2);

      // Single sweep 2..5
      d0 = done_total;
      go(2, 5, 1);
      run(12);
      chk("t1_busy_cycles", busy_run, 9);
      chk("t1_done_cycle", done_at, 10);
      chk("t1_done_count", done_total - d0, 1);
      chk("t1_sweep_idx", int'(sweep_idx), 1);
      chk("t1_log_len", log_q.size(), 9);
      for (int i = 0; i < 9; i++)
         if (i < log_q.size()) chk("t1_cnt_seq", log_q[i], t1_exp[i]);

      // Full range, three sweeps
      d0 = done_total;
      go(0, 15, 3);
      run(100);
      chk("t2_busy_cycles", busy_run, 97);
      chk("t2_done_count", done_total - d0, 1);
      chk("t2_sweep_idx", int'(sweep_idx), 3);

      // Rejected starts
      for (int r = 0; r < 2; r++) begin
         e0 = err_total; b0 = busy_total; v0 = int'(cnt_val);
         if (r == 0) go(7, 7, 2);
         else        go(2, 5, 0);
         run(3);
         chk("rej_err_count", err_total - e0, 1);
         chk("rej_busy_cycles", busy_total - b0, 0);
         chk("rej_cnt_val", int'(cnt_val), v0);
      end

      // Abort at cnt_val=4 while counting up
      d0 = done_total;
      go(1, 9, 1);
      found = 0;
      for (int i = 0; i < 30 && found == 0; i++) begin
         if (cnt_up && cnt_val == 4'd4) found = 1;
         else tick();
      end
      chk("abort_reached", found, 1);
      abort = 1'b1;
      #1;
      chk("abort_en", int'(cnt_en), 0);
      tick();
      abort = 1'b0;
      chk("abort_idle", int'(busy), 0);
      run(3);
      chk("abort_cnt_frozen", int'(cnt_val), 4);
      chk("abort_no_done", done_total - d0, 0);

      // Start while busy is ignored
      d0 = done_total;
      go(4, 10, 1);
      run(5);
      go(0, 3, 2);
      run(20);
      chk("busy_start_cycles", busy_run, 15);
      chk("busy_start_lval", int'(cnt_load_val), 4);
      chk("busy_start_done", done_total - d0, 1);

      // Async reset mid-DOWN
      d0 = done_total;
      go(3, 12, 2);
      found = 0;
      for (int i = 0; i < 60 && found == 0; i++) begin
         if (busy && !cnt_up && !cnt_load) found = 1;
         else tick();
      end
      chk("rst_reached_down", found, 1);
      #2 reset_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      run(2);
      reset_n = 1'b1;
      run(5);
      chk("midrst_no_done", done_total - d0, 0);
      chk("midrst_idle", int'(busy), 0);

      // Randomized traffic against the trace model
      for (int i = 0; i < 3000; i++) begin
         start   = ($urandom_range(0, 7) == 0);
         abort   = ($urandom_range(0, 59) == 0);
         lo      = 4'($urandom_range(0, 15));
         hi      = 4'($urandom_range(0, 15));
         nsweeps = 4'($urandom_range(0, 3));
         tick();
      end
      start = 1'b0; abort = 1'b0;
      run(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer for a WIDTH-bit up/down counter with synchronous load and count enable.
- On a start pulse, loads the counter with `lo`, counts up to `hi`, then back down to `lo`; this is one sweep. Repeats for `nsweeps` sweeps, then pulses `done`.
- Sits between a host or control FSM and the counter datapath. Drives the counter's direction, enable and load, and closes the loop on the counter's current value.

Parameters:
- WIDTH, 4, counter/bound width
- NSW_W, 4, sweep-count width

Ports:
- Clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  stops any active sequence
- lo  in  WIDTH  lower bound, latched at accepted start
- hi  in  WIDTH  upper bound, latched at accepted start
- nsweeps  in  NSW_W  sweep count, latched at accepted start
- cnt_val  in  WIDTH  current counter value
- cnt_load  out  1  counter loads `cnt_load_val` next edge
- cnt_load_val  out  WIDTH  load value (= latched `lo`)
- cnt_en  out  1  counter steps next edge
- cnt_up  out  1  direction: 1 up, 0 down
- busy  out  1  high in LOAD/UP/DOWN
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: start rejected
- sweep_idx  out  NSW_W  completed sweeps in the current run

Behaviour:
- Counter contract: load has priority over enable; `cnt_val` reflects the edge after `cnt_load`/`cnt_en`.
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - All outputs 0, including `cnt_load_val`.
  - Latched lo/hi/nsweeps and `sweep_idx` = 0.
  - Reset mid-sequence abandons the run with no `done`.
- States: IDLE, LOAD, UP, DOWN, DONE. State is registered. `busy`, `done`, `cnt_load` and `cnt_up` decode from state. `cnt_en` is combinational from state, `cnt_val` and `abort`.
- IDLE:
  - start=1 with lo<hi and nsweeps!=0: latch the bounds, sweep_idx<=0, go to LOAD.
  - start=1 otherwise: err=1 next cycle, stay in IDLE.
- LOAD: cnt_load=1 for exactly one cycle, then go to UP.
- UP (cnt_up=1):
  - cnt_val>=hi: cnt_en=0 (one dwell cycle), go to DOWN.
  - else: cnt_en=1.
- DOWN (cnt_up=0):
  - cnt_val<=lo: cnt_en=0 (dwell) and sweep_idx<=sweep_idx+1.
    - If sweep_idx+1==nsweeps go to DONE, else go to UP.
  - else: cnt_en=1.
- DONE: done=1, busy=0, go to IDLE. `sweep_idx` holds its final value until the next accepted start.
- Latency: busy cycles = 1 + nsweeps*2*(hi-lo+1). `done` follows in the next cycle.
- abort=1 in LOAD/UP/DOWN:
  - cnt_en=0 and cnt_load=0 in that same cycle (combinational gating).
  - Next state IDLE; no done, no err.
  - abort in IDLE/DONE: no effect. DONE still completes.
- start while not IDLE: ignored. It is not queued.
- start and abort together in IDLE: start wins; abort is meaningless there.
- Bound comparisons are unsigned. Using >= and <= guards against an out-of-range `cnt_val`. No arithmetic wraps inside the block.
- hi=2^WIDTH-1 and lo=0 are legal. The counter never wraps because the turnaround precedes the wrap.

Decomposition:
- Package `updown_ctrl_pkg`: state enum (IDLE, LOAD, UP, DOWN, DONE) and the default WIDTH/NSW_W constants.
- No sub-module; a single FSM plus latched-config registers.
- The bench provides a behavioural counter model honouring the counter contract.

Test Plan:
- Single sweep, lo=2 hi=5 nsweeps=1:
  - cnt_val sequence 2,3,4,5,5,4,3,2,2.
  - busy high 9 cycles, done pulses on cycle 10, sweep_idx=1.
- Three sweeps, lo=0 hi=15 (full range):
  - No counter wrap; 97 busy cycles.
  - sweep_idx steps 1,2,3 at each lo dwell; exactly one done.
- Rejected start: lo=7 hi=7 nsweeps=2 -> err pulse, busy stays 0, counter untouched. Same result with nsweeps=0.
- Abort: pulse abort at cnt_val=4 in UP, lo=1 hi=9 -> cnt_en=0 that cycle, IDLE next, no done, cnt_val frozen at 4.
- Start while busy: second start mid-run with lo=0 hi=3 -> ignored; the original bounds complete unchanged.
- Async reset: assert reset_n=0 mid-DOWN, between clock edges -> all outputs 0 immediately. After release the block idles until a new start.
